cnn_img_feeder: RTL and testbench
=================================

Name: cnn_img_feeder

Overview:
- Synthesizable image streamer that drives the top_cnn input.
- Holds NUM_IMG images plus labels in an internal store and presents them one at a time on a valid/ready handshake.
- Waits for each prediction, scores it against the stored label, and optionally loops.
- Sits between the bench/host loader and top_cnn; replaces per-cycle free-running image injection with flow-controlled, scored streaming.

Parameters:
- IMG_W, 12, image width in pixels
- IMG_H, 12, image height in pixels
- PIX_W, 8, bits per pixel
- NUM_IMG, 10, images held in store (≥1)
- ADDR_W, 4, index width, ≥ clog2(NUM_IMG)
- RES_W, 32, prediction width from the CNN
- LBL_W, 4, label width (LBL_W ≤ RES_W)
- TIMEOUT, 255, max cycles to wait for a result (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a run (honoured only in IDLE or DONE)
- loop_en  in  1  wrap to image 0 after the last image instead of finishing; sampled each wrap
- wr_en  in  1  store write strobe; ignored unless state is IDLE or DONE
- wr_addr  in  ADDR_W  store index; writes with wr_addr ≥ NUM_IMG are dropped
- wr_img  in  IMG_W*IMG_H*PIX_W  image data
- wr_label  in  LBL_W  expected digit
- img_valid  out  1  image on img_data is valid
- img_data  out  IMG_W*IMG_H*PIX_W  image to CNN
- img_ready  in  1  CNN accepts image
- res_valid  in  1  CNN prediction strobe
- res_number  in  RES_W  CNN prediction
- busy  out  1  state not IDLE/DONE
- done  out  1  high in DONE
- img_idx  out  ADDR_W  current image index
- correct_cnt  out  16  matches this run
- total_cnt  out  16  images scored this run
- timeout_cnt  out  16  results missed this run

Behaviour:
- Reset (synchronous, active-high): state=IDLE. All outputs are 0: img_valid, img_data, busy, done, img_idx, all counters. Store contents are not cleared.
- Store write:
  - wr_en with a legal state and address writes image and label in that cycle.
  - The written data is readable from the next cycle.
- States:
  - IDLE: on start → FETCH. At the same time img_idx←0 and all counters←0.
  - FETCH (1 cycle): registered store read of img_idx; img_data loaded; → SEND.
  - SEND: img_valid=1 and img_data held stable until img_valid&&img_ready. On transfer img_valid←0 next cycle, watchdog←0, → WAIT_RES.
  - WAIT_RES: on res_valid, score and advance (see below). Otherwise the watchdog increments each cycle. When watchdog==TIMEOUT, timeout_cnt+1, total_cnt+1, then advance.
  - DONE: done=1. start → FETCH with idx and counters cleared, same as the IDLE start.
- Latency: first img_valid rises 2 cycles after the cycle start is sampled. Back-to-back, the next img_valid rises 2 cycles after the res_valid cycle.
- Scoring: match when res_number == zero-extended label[img_idx]. On a match correct_cnt+1. total_cnt+1 on every scored or timed-out image.
- Advance:
  - If img_idx < NUM_IMG-1: img_idx+1 → FETCH.
  - Else if loop_en: img_idx←0 → FETCH; counters keep accumulating.
  - Else → DONE.
- Counters saturate at 16'hFFFF.
- Simultaneous events:
  - res_valid in the same cycle the watchdog reaches TIMEOUT counts as a result, not a timeout.
  - res_valid outside WAIT_RES is ignored.
  - start while busy is ignored.
- Reset mid-run: returns to IDLE next edge. img_valid drops immediately; counters clear.
- img_data stays at the last image after the transfer; it does not change until the next FETCH.

Decomposition:
- Package cnn_feed_pkg:
  - state enum (IDLE, FETCH, SEND, WAIT_RES, DONE)
  - IMG_BITS = IMG_W*IMG_H*PIX_W
  - counter width constant 16
- Sub-module cnn_img_store: NUM_IMG-entry image+label store with synchronous write and registered read (1-cycle latency). The FSM, watchdog and counters stay in cnn_img_feeder.

Test Plan:
- Run with ready/res tied high: load 10 images, labels 0..9; start, img_ready=1; CNN model returns res_number=label 3 cycles after accept. Expect done=1, total_cnt=10, correct_cnt=10, timeout_cnt=0, img_idx=9.
- Mismatch and backpressure: labels for images 2 and 7 wrong; img_ready held low for 5 cycles on image 4. Expect img_data stable throughout the stall, correct_cnt=8, total_cnt=10.
- Timeout: TIMEOUT=8, CNN never answers image 5. Expect timeout_cnt=1 and image 6 img_valid at 8+2 cycles after entering WAIT_RES. Final total_cnt=10, correct_cnt=9.
- Loop: loop_en=1, NUM_IMG=10. After 25 results expect img_idx=5 and total_cnt=25. Deassert loop_en; after the run expect done at total_cnt=30.
- Protection and coincidence: wr_en to index 3 while busy leaves the label unchanged. wr_addr=12 is dropped. start while busy is ignored. res_valid in the cycle the watchdog hits TIMEOUT increments correct_cnt, not timeout_cnt.
- Reset mid-run: rst during WAIT_RES of image 6. Expect IDLE, img_valid=0, all counters 0 next cycle. A restart then begins at image 0.

Source files
------------

// File: rtl/cnn_feed_pkg.sv
// Shared types and constants for the CNN image feeder: FSM states,
// default geometry and the saturating counter helper.
package cnn_feed_pkg;

  localparam int unsigned DEF_IMG_W = 12;
  localparam int unsigned DEF_IMG_H = 12;
  localparam int unsigned DEF_PIX_W = 8;
  localparam int unsigned IMG_BITS  = DEF_IMG_W * DEF_IMG_H * DEF_PIX_W;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_WAIT_RES,
    ST_DONE
  } state_e;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : cnt_t'(v + 1'b1);
  endfunction

endpackage

// File: rtl/cnn_img_feeder_if.sv
// Image/result handshake between the feeder (master) and the CNN (slave).
interface cnn_img_feeder_if #(
  parameter int unsigned IMG_BITS = cnn_feed_pkg::IMG_BITS,
  parameter int unsigned RES_W    = 32
);
  logic                img_valid;
  logic [IMG_BITS-1:0] img_data;
  logic                img_ready;
  logic                res_valid;
  logic [RES_W-1:0]    res_number;

  modport master (
    output img_valid, img_data,
    input  img_ready, res_valid, res_number
  );

  modport slave (
    input  img_valid, img_data,
    output img_ready, res_valid, res_number
  );
endinterface

// File: rtl/cnn_img_store.sv
// Image + label store: synchronous write, registered read (1-cycle latency).
// The read register holds its value until the next read enable.
module cnn_img_store #(
  parameter int unsigned NUM_IMG = 10,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 1152,
  parameter int unsigned LBL_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wimg,
  input  logic [LBL_W-1:0]  wlabel,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rimg,
  output logic [LBL_W-1:0]  rlabel
);

  logic [DATA_W-1:0] img_mem [NUM_IMG];
  logic [LBL_W-1:0]  lbl_mem [NUM_IMG];
  logic              wr_ok;
  logic [DATA_W-1:0] rd_img_d, rd_img_q;
  logic [LBL_W-1:0]  rd_lbl_d, rd_lbl_q;

  // Extra bit on the compare so NUM_IMG == 2**ADDR_W does not wrap to zero.
  assign wr_ok = we && ({1'b0, waddr} < (ADDR_W+1)'(NUM_IMG));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      img_mem[waddr] <= wimg;
      lbl_mem[waddr] <= wlabel;
    end
  end

  always_comb begin
    rd_img_d = rd_img_q;
    rd_lbl_d = rd_lbl_q;
    if (re) begin
      rd_img_d = img_mem[raddr];
      rd_lbl_d = lbl_mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_img_q <= '0;
      rd_lbl_q <= '0;
    end else begin
      rd_img_q <= rd_img_d;
      rd_lbl_q <= rd_lbl_d;
    end
  end

  assign rimg   = rd_img_q;
  assign rlabel = rd_lbl_q;

endmodule

// File: rtl/cnn_img_feeder.sv
// Streams stored images to the CNN over valid/ready, scores each prediction
// against its label, counts matches/timeouts and optionally loops.
module cnn_img_feeder
  import cnn_feed_pkg::*;
#(
  parameter int unsigned IMG_W   = DEF_IMG_W,
  parameter int unsigned IMG_H   = DEF_IMG_H,
  parameter int unsigned PIX_W   = DEF_PIX_W,
  parameter int unsigned NUM_IMG = 10,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned RES_W   = 32,
  parameter int unsigned LBL_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         loop_en,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [IMG_W*IMG_H*PIX_W-1:0] wr_img,
  input  logic [LBL_W-1:0]             wr_label,
  cnn_img_feeder_if.master             cnn,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_W-1:0]            img_idx,
  output logic [CNT_W-1:0]             correct_cnt,
  output logic [CNT_W-1:0]             total_cnt,
  output logic [CNT_W-1:0]             timeout_cnt
);

  localparam int unsigned DATA_W = IMG_W * IMG_H * PIX_W;
  localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] idx_d, idx_q;
  logic [WD_W-1:0]   wd_d, wd_q;
  cnt_t              cor_d, cor_q, tot_d, tot_q, tmo_d, tmo_q;
  logic              advance;
  logic              store_we;
  logic [LBL_W-1:0]  cur_label;

  assign store_we = wr_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  cnn_img_store #(
    .NUM_IMG (NUM_IMG),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LBL_W   (LBL_W)
  ) u_store (
    .clk    (clk),
    .rst    (rst),
    .we     (store_we),
    .waddr  (wr_addr),
    .wimg   (wr_img),
    .wlabel (wr_label),
    .re     (state_q == ST_FETCH),
    .raddr  (idx_q),
    .rimg   (cnn.img_data),
    .rlabel (cur_label)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    cor_d   = cor_q;
    tot_d   = tot_q;
    tmo_d   = tmo_q;
    advance = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_FETCH;
          idx_d   = '0;
          cor_d   = '0;
          tot_d   = '0;
          tmo_d   = '0;
        end
      end
      ST_FETCH: state_d = ST_SEND;
      ST_SEND: begin
        if (cnn.img_ready) begin
          state_d = ST_WAIT_RES;
          wd_d    = '0;
        end
      end
      ST_WAIT_RES: begin
        // A result arriving on the timeout cycle wins over the timeout.
        if (cnn.res_valid) begin
          advance = 1'b1;
          tot_d   = sat_inc(tot_q);
          if (cnn.res_number == RES_W'(cur_label)) cor_d = sat_inc(cor_q);
        end else if (wd_q == WD_W'(TIMEOUT)) begin
          advance = 1'b1;
          tot_d   = sat_inc(tot_q);
          tmo_d   = sat_inc(tmo_q);
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (idx_q < ADDR_W'(NUM_IMG - 1)) begin
        idx_d   = idx_q + ADDR_W'(1);
        state_d = ST_FETCH;
      end else if (loop_en) begin
        idx_d   = '0;
        state_d = ST_FETCH;
      end else begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wd_q    <= '0;
      cor_q   <= '0;
      tot_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      cor_q   <= cor_d;
      tot_q   <= tot_d;
      tmo_q   <= tmo_d;
    end
  end

  assign cnn.img_valid = (state_q == ST_SEND);
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done          = (state_q == ST_DONE);
  assign img_idx       = idx_q;
  assign correct_cnt   = cor_q;
  assign total_cnt     = tot_q;
  assign timeout_cnt   = tmo_q;

endmodule

// File: tb/tb_cnn_img_feeder.sv
// Bench for cnn_img_feeder: a behavioural CNN responder plus directed runs
// with randomized images/labels, scored against per-image expectations.
module tb_cnn_img_feeder;
  import cnn_feed_pkg::*;

  localparam int unsigned NIMG = 10;
  localparam int unsigned AW   = 4;
  localparam int unsigned RW   = 32;
  localparam int unsigned LW   = 4;
  localparam int unsigned TO   = 8;
  localparam int unsigned IB   = 12 * 12 * 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          loop_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [IB-1:0] wr_img = '0;
  logic [LW-1:0] wr_label = '0;
  logic          busy, done;
  logic [AW-1:0] img_idx;
  logic [15:0]   correct_cnt, total_cnt, timeout_cnt;

  cnn_img_feeder_if #(.IMG_BITS(IB), .RES_W(RW)) cnn_bus ();

  cnn_img_feeder #(
    .IMG_W(12), .IMG_H(12), .PIX_W(8), .NUM_IMG(NIMG), .ADDR_W(AW),
    .RES_W(RW), .LBL_W(LW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .loop_en(loop_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_img(wr_img), .wr_label(wr_label),
    .cnn(cnn_bus), .busy(busy), .done(done), .img_idx(img_idx),
    .correct_cnt(correct_cnt), .total_cnt(total_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference store and CNN behaviour per image index.
  logic [IB-1:0] m_img [NIMG];
  logic [LW-1:0] m_lbl [NIMG];
  int            ans_val [NIMG];
  bit            answer [NIMG];
  int            delay [NIMG];
  int            stall [NIMG];

  int vectors = 0;
  int miscompares = 0;
  int rx_cnt = 0;
  int res_n = 0;
  int exp_rise_cyc = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_img(input string tag, input logic [IB-1:0] got, input logic [IB-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got ..%h expected ..%h", tag, got[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [IB-1:0] rand_img();
    logic [IB-1:0] r;
    for (int w = 0; w < int'(IB / 32); w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  // Behavioural CNN: acts on the falling edge, drives ready/result for the next rising edge.
  initial begin : responder
    bit pending;
    int cd, pend_val, stall_left, cur;
    bit prev_valid;
    pending = 0; cd = 0; pend_val = 0; stall_left = 0; prev_valid = 0;
    cnn_bus.img_ready  = 1'b1;
    cnn_bus.res_valid  = 1'b0;
    cnn_bus.res_number = '0;
    forever begin
      @(negedge clk);
      cnn_bus.res_valid = 1'b0;
      if (rst) begin
        pending = 0; stall_left = 0; prev_valid = 0;
        exp_rise_cyc = -1;
        cnn_bus.img_ready = 1'b1;
        continue;
      end
      if (pending) begin
        if (cd == 0) begin
          cnn_bus.res_valid  = 1'b1;
          cnn_bus.res_number = RW'(pend_val);
          pending = 0;
          res_n++;
          exp_rise_cyc = cyc + 2;
        end else cd--;
      end
      if (cnn_bus.img_valid === 1'b1) begin
        cur = rx_cnt % NIMG;
        if (!prev_valid) begin
          if (exp_rise_cyc >= 0) check("valid_rise_cycle", 64'(cyc), 64'(exp_rise_cyc));
          exp_rise_cyc = -1;
          stall_left = stall[cur];
        end
        if (stall_left > 0) begin
          cnn_bus.img_ready = 1'b0;
          stall_left--;
          check_img("stall_data", cnn_bus.img_data, m_img[cur]);
        end else begin
          cnn_bus.img_ready = 1'b1;
          check("accept_idx", 64'(img_idx), 64'(cur));
          check_img("accept_data", cnn_bus.img_data, m_img[cur]);
          rx_cnt++;
          if (answer[cur]) begin
            pending = 1; cd = delay[cur] - 1; pend_val = ans_val[cur];
          end else begin
            exp_rise_cyc = cyc + TO + 3;
          end
        end
        prev_valid = 1;
      end else begin
        cnn_bus.img_ready = 1'b1;
        prev_valid = 0;
      end
    end
  end

  initial begin : global_limit
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic drive_write(input logic [AW-1:0] a, input logic [IB-1:0] d, input logic [LW-1:0] l);
    wr_en = 1'b1; wr_addr = a; wr_img = d; wr_label = l;
    @(posedge clk); #2;
    wr_en = 1'b0;
  endtask

  task automatic load(input int i, input int lbl);
    m_img[i] = rand_img();
    m_lbl[i] = LW'(lbl);
    drive_write(AW'(i), m_img[i], m_lbl[i]);
  endtask

  task automatic set_cnn_defaults();
    for (int i = 0; i < int'(NIMG); i++) begin
      ans_val[i] = int'(m_lbl[i]); answer[i] = 1; delay[i] = 3; stall[i] = 0;
    end
  endtask

  function automatic bit img_ok(input int i);
    return answer[i] && (ans_val[i] == int'(m_lbl[i]));
  endfunction

  task automatic start_run();
    rx_cnt = 0; res_n = 0;
    start = 1'b1;
    exp_rise_cyc = cyc + 2;
    @(posedge clk); #2;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("done_after_start", 64'(done), 64'd0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int n = 0; n < budget && done !== 1'b1; n++) begin
      @(posedge clk); #2;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic finish_check(input string tag);
    int ec, et;
    ec = 0; et = 0;
    for (int i = 0; i < int'(NIMG); i++) begin
      if (img_ok(i)) ec++;
      if (!answer[i]) et++;
    end
    wait_done(tag, 400);
    check({tag, "_total"}, 64'(total_cnt), 64'(NIMG));
    check({tag, "_correct"}, 64'(correct_cnt), 64'(ec));
    check({tag, "_timeouts"}, 64'(timeout_cnt), 64'(et));
    check({tag, "_idx"}, 64'(img_idx), 64'(NIMG - 1));
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin : main
    int ec;
    logic [LW-1:0] bad_lbl;
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 64'(cnn_bus.img_valid), 64'd0);
    check_img("rst_data", cnn_bus.img_data, '0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_idx", 64'(img_idx), 64'd0);
    check("rst_cnts", {16'd0, correct_cnt, total_cnt, timeout_cnt}, 64'd0);
    rst = 1'b0;

    // Labels 0..9, prompt correct answers, no backpressure.
    for (int i = 0; i < int'(NIMG); i++) load(i, i);
    set_cnn_defaults();
    start_run();
    finish_check("basic");

    // Random labels, wrong predictions on 2 and 7, five-cycle stall on 4.
    for (int i = 0; i < int'(NIMG); i++) load(i, int'($urandom_range(0, 9)));
    set_cnn_defaults();
    ans_val[2] = (int'(m_lbl[2]) + 1) % 10;
    ans_val[7] = (int'(m_lbl[7]) + 1) % 10;
    stall[4] = 5;
    start_run();
    finish_check("mismatch_stall");

    // Image 5 never answered.
    set_cnn_defaults();
    answer[5] = 0;
    start_run();
    finish_check("timeout");

    // Loop for 25 results, then let the run finish at the end of the lap.
    set_cnn_defaults();
    loop_en = 1'b1;
    start_run();
    for (int n = 0; n < 600 && res_n < 25; n++) begin
      @(posedge clk); #2;
    end
    check("loop_reached25", 64'(res_n >= 25), 64'd1);
    ec = 0;
    for (int r = 0; r < 25; r++) if (img_ok(r % NIMG)) ec++;
    check("loop_total25", 64'(total_cnt), 64'd25);
    check("loop_correct25", 64'(correct_cnt), 64'(ec));
    check("loop_idx25", 64'(img_idx), 64'(25 % NIMG));
    loop_en = 1'b0;
    wait_done("loop", 400);
    check("loop_total_final", 64'(total_cnt), 64'(3 * NIMG));
    check("loop_correct_final", 64'(correct_cnt), 64'(3 * NIMG));
    check("loop_timeouts", 64'(timeout_cnt), 64'd0);

    // Dropped writes, ignored start, result on the watchdog's last cycle.
    set_cnn_defaults();
    delay[4] = TO + 1;
    drive_write(AW'(12), rand_img(), LW'(5));
    start_run();
    repeat (2) begin
      @(posedge clk); #2;
    end
    bad_lbl = LW'((int'(m_lbl[3]) + 1) % 10);
    drive_write(AW'(3), rand_img(), bad_lbl);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    finish_check("protect");

    // Reset while waiting on image 6, then a clean rerun from image 0.
    set_cnn_defaults();
    delay[6] = 6;
    start_run();
    for (int n = 0; n < 300 && rx_cnt < 7; n++) begin
      @(posedge clk); #2;
    end
    check("midrun_reached6", 64'(rx_cnt >= 7), 64'd1);
    rst = 1'b1;
    @(posedge clk); #2;
    check("midrst_valid", 64'(cnn_bus.img_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_idx", 64'(img_idx), 64'd0);
    check("midrst_cnts", {16'd0, correct_cnt, total_cnt, timeout_cnt}, 64'd0);
    rst = 1'b0;
    delay[6] = 3;
    start_run();
    finish_check("rerun");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
